// File: rtl/waveform_monitor.sv
// waveform_monitor: receive-side checker for the biphasic stimulus generator.
// Measures cathodic/inter-phase/anodic durations and amplitudes of one armed
// waveform and flags amplitude, overlap, ordering and timeout errors.
// Optional feature macro: WAVEMON_CHARGE_BAL_EN (adds charge products and err_charge).
module waveform_monitor #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned AMP_W       = 6,
  parameter int unsigned IPD_TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [AMP_W-1:0] sink,
  input  logic [AMP_W-1:0] src,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] m_ktp,
  output logic [AMP_W-1:0] m_sktp,
  output logic [CNT_W-1:0] m_ipd,
  output logic [CNT_W-1:0] m_adp,
  output logic [AMP_W-1:0] m_sadp,
  output logic             err_amp,
  output logic             err_overlap,
  output logic             err_order,
  output logic             err_timeout
`ifdef WAVEMON_CHARGE_BAL_EN
  ,
  output logic [CNT_W+AMP_W-1:0] q_cath,
  output logic [CNT_W+AMP_W-1:0] q_anod,
  output logic                   err_charge
`endif
);

  localparam int unsigned Q_W = CNT_W + AMP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(IPD_TIMEOUT);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_CATH   = 3'd2;
  localparam logic [2:0] ST_IPD    = 3'd3;
  localparam logic [2:0] ST_ANOD   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  logic [2:0]       r_state, w_state;
  logic             r_busy, w_busy;
  logic             r_valid, w_valid;
  logic [CNT_W-1:0] r_ktp, w_ktp;
  logic [AMP_W-1:0] r_sktp, w_sktp;
  logic [CNT_W-1:0] r_ipd, w_ipd;
  logic [CNT_W-1:0] r_adp, w_adp;
  logic [AMP_W-1:0] r_sadp, w_sadp;
  logic             r_err_amp, w_err_amp;
  logic             r_err_ovl, w_err_ovl;
  logic             r_err_ord, w_err_ord;
  logic             r_err_to, w_err_to;
  logic             w_sink_nz, w_src_nz;
`ifdef WAVEMON_CHARGE_BAL_EN
  logic [Q_W-1:0]   r_q_cath, w_q_cath;
  logic [Q_W-1:0]   r_q_anod, w_q_anod;
  logic             r_err_chg, w_err_chg;
`endif

  // Saturating increment for all duration counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign w_sink_nz = |sink;
  assign w_src_nz  = |src;

  // State and measurement registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_ktp     <= '0;
      r_sktp    <= '0;
      r_ipd     <= '0;
      r_adp     <= '0;
      r_sadp    <= '0;
      r_err_amp <= 1'b0;
      r_err_ovl <= 1'b0;
      r_err_ord <= 1'b0;
      r_err_to  <= 1'b0;
`ifdef WAVEMON_CHARGE_BAL_EN
      r_q_cath  <= '0;
      r_q_anod  <= '0;
      r_err_chg <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_busy    <= w_busy;
      r_valid   <= w_valid;
      r_ktp     <= w_ktp;
      r_sktp    <= w_sktp;
      r_ipd     <= w_ipd;
      r_adp     <= w_adp;
      r_sadp    <= w_sadp;
      r_err_amp <= w_err_amp;
      r_err_ovl <= w_err_ovl;
      r_err_ord <= w_err_ord;
      r_err_to  <= w_err_to;
`ifdef WAVEMON_CHARGE_BAL_EN
      r_q_cath  <= w_q_cath;
      r_q_anod  <= w_q_anod;
      r_err_chg <= w_err_chg;
`endif
    end
  end

  // Phase tracking, measurement update and termination detection
  always_comb begin
    w_state   = r_state;
    w_busy    = r_busy;
    w_valid   = 1'b0;
    w_ktp     = r_ktp;
    w_sktp    = r_sktp;
    w_ipd     = r_ipd;
    w_adp     = r_adp;
    w_sadp    = r_sadp;
    w_err_amp = r_err_amp;
    w_err_ovl = r_err_ovl;
    w_err_ord = r_err_ord;
    w_err_to  = r_err_to;
`ifdef WAVEMON_CHARGE_BAL_EN
    w_q_cath  = r_q_cath;
    w_q_anod  = r_q_anod;
    w_err_chg = r_err_chg;
`endif
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_state   = ST_WAIT;
          w_busy    = 1'b1;
          w_ktp     = '0;
          w_sktp    = '0;
          w_ipd     = '0;
          w_adp     = '0;
          w_sadp    = '0;
          w_err_amp = 1'b0;
          w_err_ovl = 1'b0;
          w_err_ord = 1'b0;
          w_err_to  = 1'b0;
`ifdef WAVEMON_CHARGE_BAL_EN
          w_q_cath  = '0;
          w_q_anod  = '0;
          w_err_chg = 1'b0;
`endif
        end
      end
      ST_WAIT: begin
        if (w_sink_nz) begin
          w_state = ST_CATH;
          w_ktp   = CNT_W'(1);
          w_sktp  = sink;
          if (w_src_nz) begin
            w_err_ovl = 1'b1;
            w_state   = ST_FINISH;
          end
        end else if (w_src_nz) begin
          w_err_ord = 1'b1;
          w_state   = ST_FINISH;
        end
      end
      ST_CATH: begin
        if (w_sink_nz) begin
          w_ktp = sat_inc(r_ktp);
          if (sink != r_sktp) w_err_amp = 1'b1;
          if (w_src_nz) begin
            w_err_ovl = 1'b1;
            w_state   = ST_FINISH;
          end
        end else if (w_src_nz) begin
          // Anodic phase starts with no inter-phase gap
          w_ipd   = '0;
          w_adp   = CNT_W'(1);
          w_sadp  = src;
          w_state = ST_ANOD;
        end else begin
          w_ipd   = CNT_W'(1);
          w_state = ST_IPD;
          if (w_ipd >= TIMEOUT) begin
            w_err_to = 1'b1;
            w_state  = ST_FINISH;
          end
        end
      end
      ST_IPD: begin
        if (w_sink_nz && w_src_nz) begin
          w_err_ovl = 1'b1;
          w_state   = ST_FINISH;
        end else if (w_src_nz) begin
          w_adp   = CNT_W'(1);
          w_sadp  = src;
          w_state = ST_ANOD;
        end else begin
          // Sink re-activating in the gap is an amplitude fault; keep counting
          if (w_sink_nz) w_err_amp = 1'b1;
          w_ipd = sat_inc(r_ipd);
          if (w_ipd >= TIMEOUT) begin
            w_err_to = 1'b1;
            w_state  = ST_FINISH;
          end
        end
      end
      ST_ANOD: begin
        if (w_sink_nz && w_src_nz) begin
          w_err_ovl = 1'b1;
          w_state   = ST_FINISH;
        end else if (w_src_nz) begin
          w_adp = sat_inc(r_adp);
          if (src != r_sadp) w_err_amp = 1'b1;
        end else begin
          w_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
    endcase

    // Entering FINISH: publish the result set in the same edge
    if ((w_state == ST_FINISH) && (r_state != ST_FINISH)) begin
      w_valid = 1'b1;
      w_busy  = 1'b0;
`ifdef WAVEMON_CHARGE_BAL_EN
      w_q_cath  = Q_W'(w_ktp) * Q_W'(w_sktp);
      w_q_anod  = Q_W'(w_adp) * Q_W'(w_sadp);
      w_err_chg = (w_q_cath != w_q_anod) &&
                  !(w_err_amp || w_err_ovl || w_err_ord || w_err_to);
`endif
    end
  end

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign m_ktp       = r_ktp;
  assign m_sktp      = r_sktp;
  assign m_ipd       = r_ipd;
  assign m_adp       = r_adp;
  assign m_sadp      = r_sadp;
  assign err_amp     = r_err_amp;
  assign err_overlap = r_err_ovl;
  assign err_order   = r_err_ord;
  assign err_timeout = r_err_to;
`ifdef WAVEMON_CHARGE_BAL_EN
  assign q_cath      = r_q_cath;
  assign q_anod      = r_q_anod;
  assign err_charge  = r_err_chg;
`endif

endmodule
